// File: rtl/mem_pkg.sv
// mem_pkg: shared state/owner encodings, default widths and burst-count helper for mem_arbiter
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    // Consecutive-grant count: restarts at 1 on an owner change, saturates at the cap
    function automatic logic [3:0] burst_next(input logic [3:0] cnt, input logic same, input logic [3:0] cap);
        return !same ? 4'd1 : (cnt >= cap ? cap : cnt + 4'd1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention
module mem_arb_pick
    import mem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic       last_owner,
    input  logic [3:0] burst_cnt,
    output logic       winner
);

    logic both_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Alternate on contention; the very first grant after reset (count still 0) goes to the CPU
    assign both_win = (burst_cnt == 4'd0) ? OWN_CPU : ~last_owner;
`else
    // CPU priority unless it has used up its burst allowance
    assign both_win = (burst_cnt >= 4'(MAX_BURST)) ? ~last_owner : OWN_CPU;
`endif

    assign winner = (cpu_req && dma_req) ? both_win : (dma_req ? OWN_DMA : OWN_CPU);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU/DMA) arbiter for a shared RAM; optional MEM_ARB_ROUND_ROBIN_EN
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic              ram_oe,
    output logic              grant_dma
);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [3:0]        burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              oe_q, oe_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              win;

    // owner_q doubles as last_owner: it is only rewritten when a new grant is made
    mem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .cpu_req   (cpu_req),
        .dma_req   (dma_req),
        .last_owner(owner_q),
        .burst_cnt (burst_q),
        .winner    (win)
    );

    // Next-state: grant in IDLE, drive RAM for one cycle in ACCESS, pulse ack in ACK
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_d     = burst_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        oe_d        = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (cpu_req || dma_req) begin
                state_d = ST_ACCESS;
                owner_d = win;
                burst_d = burst_next(burst_q, win == owner_q, 4'(MAX_BURST));
                addr_d  = win ? dma_addr : cpu_addr;
                wdata_d = win ? dma_wdata : cpu_wdata;
                we_d    = win ? dma_we : cpu_we;
                oe_d    = ~we_d;
            end
            ST_ACCESS: begin
                state_d     = ST_ACK;
                cpu_rdata_d = (oe_q && !owner_q) ? ram_rdata : cpu_rdata_q;
                dma_rdata_d = (oe_q && owner_q) ? ram_rdata : dma_rdata_q;
                cpu_ack_d   = ~owner_q;
                dma_ack_d   = owner_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            burst_q     <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_q     <= burst_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = we_q;
    assign ram_oe    = oe_q;
    assign grant_dma = owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a RAM model and a request-level reference model
module tb_mem_arbiter;

    localparam int MAX_BURST = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } req_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
    logic [7:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata, ram_rdata;
    logic       cpu_ack, dma_ack, ram_we, ram_oe, grant_dma;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    req_t       cq[$], dq[$];
    bit         glog[$];
    int         ack_log[$];
    int         n_cmp = 0, n_err = 0, cyc = 0, run = 0;
    bit         last = 1'b0, started = 1'b0, ack_pend = 1'b0, ack_w = 1'b0, w;
    logic       creq_s = 1'b0, dreq_s = 1'b0;
    logic [7:0] exp_crd = '0, exp_drd = '0;
    req_t       r;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .ram_oe(ram_oe), .grant_dma(grant_dma)
    );

    // RAM: asynchronous read while oe, write on the clock edge while we
    assign ram_rdata = ram_oe ? mem[ram_addr] : 8'h00;
    always @(posedge clk) begin
        if (reset) for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        creq_s <= cpu_req;
        dreq_s <= dma_req;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        cq.delete(); dq.delete(); glog.delete(); ack_log.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        last = 1'b0; run = 0; started = 1'b0; ack_pend = 1'b0;
        exp_crd = 8'h00; exp_drd = 8'h00;
    endtask

    // Reference model: decide each grant from the spec's arbitration rules, then expect the ack a cycle later
    always @(negedge clk) begin
        if (!reset) begin
            if (ack_pend) begin
                chk("cpu_ack", cpu_ack, !ack_w);
                chk("dma_ack", dma_ack, ack_w);
                chk("cpu_rdata", cpu_rdata, exp_crd);
                chk("dma_rdata", dma_rdata, exp_drd);
                if (ack_w && dq.size() > 0) void'(dq.pop_front());
                if (!ack_w && cq.size() > 0) void'(cq.pop_front());
                ack_log.push_back(cyc);
                ack_pend = 1'b0;
            end else chk("idle_acks", {cpu_ack, dma_ack}, 2'b00);
            if (ram_we || ram_oe) begin
                chk("we_oe_exclusive", ram_we & ram_oe, 1'b0);
                if (creq_s && dreq_s) w = (run >= MAX_BURST || (RR && started)) ? !last : 1'b0;
                else w = dreq_s;
                chk("grant_dma", grant_dma, w);
                if ((w ? dq.size() : cq.size()) == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL access_without_request: grant_dma=%0d with no pending request (cycle %0d)", grant_dma, cyc);
                end else begin
                    r = w ? dq[0] : cq[0];
                    chk("ram_addr", ram_addr, r.addr);
                    chk("ram_we", ram_we, r.we);
                    chk("ram_oe", ram_oe, !r.we);
                    if (r.we) begin
                        chk("ram_wdata", ram_wdata, r.wdata);
                        ref_mem[r.addr] = r.wdata;
                    end else if (w) exp_drd = ref_mem[r.addr];
                    else exp_crd = ref_mem[r.addr];
                end
                run = (w == last) ? ((run < MAX_BURST) ? run + 1 : run) : 1;
                last = w; started = 1'b1;
                glog.push_back(w);
                ack_pend = 1'b1; ack_w = w;
            end
        end
    end

    task automatic issue(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d);
        req_t q;
        @(posedge clk); #1;
        q.we = we; q.addr = a; q.wdata = d;
        if (p) begin
            dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d; dq.push_back(q);
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cq.push_back(q);
        end
    endtask

    task automatic drop(input bit p);
        @(posedge clk); #1;
        if (p) dma_req = 1'b0; else cpu_req = 1'b0;
    endtask

    task automatic wait_ack(input bit p, output int t);
        t = 0;
        do begin
            @(negedge clk); t++;
        end while (!(p ? dma_ack : cpu_ack) && t < 40);
        if (!(p ? dma_ack : cpu_ack)) begin
            n_cmp++; n_err++;
            $display("FAIL ack_timeout: port %0d no ack after %0d cycles, expected one", p, t);
        end
    endtask

    task automatic run_port(input bit p, input int n, input int idle_max);
        int t;
        for (int i = 0; i < n; i++) begin
            issue(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
            wait_ack(p, t);
            if (i == n - 1 || $urandom_range(0, idle_max) != 0) begin
                drop(p);
                repeat ($urandom_range(0, idle_max)) @(posedge clk);
            end
        end
    endtask

    task automatic burst(input bit p, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            issue(p, 1'b1, 8'(8'h40 + i + (p ? 8'h20 : 8'h00)), 8'($urandom));
            wait_ack(p, t);
        end
        drop(p);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_req = 1'b0; dma_req = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        @(negedge clk);
        chk(nm, {cpu_ack, dma_ack, ram_we, ram_oe, grant_dma, ram_addr, ram_wdata, cpu_rdata, dma_rdata}, 64'h0);
    endtask

    initial begin
        int t;
        logic [9:0] pat;
        do_reset();
        chk_zero("reset_outputs");

        // CPU write then read back
        issue(0, 1'b1, 8'h10, 8'hA5); wait_ack(0, t); chk("wr_latency", t, 3); drop(0);
        issue(0, 1'b0, 8'h10, 8'h00); wait_ack(0, t); chk("rd_latency", t, 3);
        chk("cpu_readback", cpu_rdata, 8'hA5); drop(0);

        // Simultaneous first requests after reset
        do_reset();
        fork
            begin issue(0, 1'b1, 8'h01, 8'h11); wait_ack(0, t); drop(0); end
            begin issue(1, 1'b1, 8'h02, 8'h22); wait_ack(1, t); drop(1); end
        join
        chk("simul_grants", glog.size(), 2);
        if (glog.size() == 2) chk("simul_order", {glog[0], glog[1]}, 2'b01);
        if (ack_log.size() == 2) chk("simul_ack_gap", ack_log[1] - ack_log[0], 3);

        // Both requesting continuously
        do_reset();
        pat = RR ? 10'b1010101010 : 10'b1000010000;
        fork
            burst(0, RR ? 5 : 8);
            burst(1, RR ? 5 : 2);
        join
        chk("contend_grants", glog.size(), 10);
        for (int i = 0; i < 10 && i < glog.size(); i++) chk($sformatf("contend_grant_%0d", i), glog[i], pat[i]);

        // Reset during a DMA write access
        do_reset();
        issue(1, 1'b1, 8'h20, 8'h5A);
        t = 0;
        do begin @(negedge clk); t++; end while (!ram_we && t < 10);
        chk("dma_wr_access", {ram_we, grant_dma, ram_addr}, {1'b1, 1'b1, 8'h20});
        reset = 1'b1; dma_req = 1'b0;
        clear_model();
        @(posedge clk);
        chk_zero("mid_access_reset");
        @(posedge clk); #1 reset = 1'b0;
        issue(0, 1'b0, 8'h30, 8'h00); wait_ack(0, t); chk("post_reset_latency", t, 3); drop(0);

        // Lone DMA requester, back to back
        do_reset();
        for (int i = 0; i < 10; i++) begin
            issue(1, 1'($urandom_range(0, 1)), 8'(i), 8'($urandom));
            wait_ack(1, t);
            chk("dma_latency", t, 3);
        end
        drop(1);
        chk("dma_ack_count", ack_log.size(), 10);
        for (int i = 1; i < ack_log.size(); i++) chk("dma_ack_spacing", ack_log[i] - ack_log[i-1], 3);

        // Randomised traffic from both ports
        do_reset();
        fork
            run_port(0, 80, 3);
            run_port(1, 80, 3);
        join
        repeat (4) @(negedge clk);
        chk("queues_drained", cq.size() + dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
